// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues instruction-memory reads at fetch_pc under a credit limit,
// buffers returned words with their PC in an in-order FIFO and flushes on redirect.
module instr_fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              redirect,
    output logic              pc_advance,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              resp_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_fifo_cnt;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop_cnt;
    logic              r_resp_err;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_q_wr;
    logic [PW-1:0]     r_q_rd;
    logic [ADDR_W-1:0] r_fifo_pc    [DEPTH];
    logic [DATA_W-1:0] r_fifo_instr [DEPTH];
    logic [ADDR_W-1:0] r_q_pc       [DEPTH];

    logic [CW:0]   w_used;
    logic          w_req;
    logic          w_gnt;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic          w_unexp;
    logic [CW-1:0] w_live;

    // Credits cover both buffered words and requests still in flight.
    assign w_used  = {1'b0, r_fifo_cnt} + {1'b0, r_outstanding};
    assign w_req   = !reset && (r_state == S_RUN) && !redirect && (w_used < DEPTH[CW:0]);
    assign w_gnt   = w_req && imem_gnt;
    assign w_resp  = imem_rvalid && (r_state == S_RUN) && (r_outstanding != '0);
    assign w_unexp = imem_rvalid && (r_state == S_RUN) && (r_outstanding == '0);
    assign w_push  = w_resp && !redirect;
    assign w_valid = (r_fifo_cnt != '0);
    assign w_pop   = w_valid && if_ready;
    assign w_live  = r_outstanding - CW'(w_resp);

    assign imem_req   = w_req;
    assign imem_addr  = fetch_pc;
    assign pc_advance = w_gnt;
    assign if_valid   = w_valid;
    assign if_instr   = w_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign if_pc      = w_valid ? r_fifo_pc[r_rd_ptr]    : '0;
    assign resp_err   = r_resp_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_RUN;
            r_fifo_cnt    <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_resp_err    <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_q_wr        <= '0;
            r_q_rd        <= '0;
        end else begin
            if (w_unexp)
                r_resp_err <= 1'b1;
            if (redirect) begin
                r_fifo_cnt    <= '0;
                r_outstanding <= '0;
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_q_wr        <= '0;
                r_q_rd        <= '0;
            end
            case (r_state)
                S_RUN: begin
                    if (redirect) begin
                        r_drop_cnt <= w_live;
                        r_state    <= (w_live != '0) ? S_FLUSH : S_RUN;
                    end else begin
                        r_fifo_cnt    <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
                        r_outstanding <= r_outstanding + CW'(w_gnt) - CW'(w_resp);
                        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                        if (w_gnt)  r_q_wr   <= r_q_wr + PW'(1);
                        if (w_resp) r_q_rd   <= r_q_rd + PW'(1);
                    end
                end
                S_FLUSH: begin
                    // Stale responses drain here; return to RUN once the last one lands.
                    if (r_drop_cnt == '0) begin
                        r_state <= S_RUN;
                    end else if (imem_rvalid) begin
                        r_drop_cnt <= r_drop_cnt - CW'(1);
                        if (r_drop_cnt == CW'(1))
                            r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_gnt)
            r_q_pc[r_q_wr] <= fetch_pc;
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_q_pc[r_q_rd];
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: per-cycle vector table plus hand-written
// sequences for unexpected responses and reset with requests in flight.
module tb_instr_fetch_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        redirect;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .redirect(redirect),
        .pc_advance(pc_advance), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] fpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        redir;
        logic        e_req;
        logic        e_adv;
        logic        e_vld;
        logic [31:0] e_pc;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic add(input logic rst, input logic [31:0] fpc, input logic gnt,
                       input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic redir, input logic e_req, input logic e_adv,
                       input logic e_vld, input logic [31:0] e_pc, input logic e_err);
        vec_t v;
        v.rst = rst; v.fpc = fpc; v.gnt = gnt; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.redir = redir; v.e_req = e_req; v.e_adv = e_adv; v.e_vld = e_vld;
        v.e_pc = e_pc; v.e_err = e_err;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [31:0] fpc, input logic gnt,
                         input logic rv, input logic [31:0] rdata, input logic rdy,
                         input logic redir);
        @(negedge clk);
        reset = rst; fetch_pc = fpc; imem_gnt = gnt; imem_rvalid = rv;
        imem_rdata = rdata; if_ready = rdy; redirect = redir;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic e_req, input logic e_adv,
                           input logic e_vld, input logic [31:0] e_pc, input logic e_err);
        chk({tag, ".req"},   {31'b0, imem_req},   {31'b0, e_req});
        chk({tag, ".adv"},   {31'b0, pc_advance}, {31'b0, e_adv});
        chk({tag, ".vld"},   {31'b0, if_valid},   {31'b0, e_vld});
        chk({tag, ".pc"},    if_pc,               e_pc);
        chk({tag, ".instr"}, if_instr,            e_vld ? word_of(e_pc) : 32'h0);
        chk({tag, ".err"},   {31'b0, resp_err},   {31'b0, e_err});
        if (imem_req) chk({tag, ".addr"}, imem_addr, fetch_pc);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fetch_pc = '0; redirect = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;

        //  rst fpc  gnt rv rpc rdy rdr | req adv vld pc err
        add(1, 0,    1, 0, 0,  1, 0,    0, 0, 0, 0,  0);
        add(1, 0,    1, 0, 0,  1, 0,    0, 0, 0, 0,  0);
        // streaming fetch, 1-cycle responses, decode always ready
        add(0, 0,    1, 0, 0,  1, 0,    1, 1, 0, 0,  0);
        add(0, 4,    1, 1, 0,  1, 0,    1, 1, 0, 0,  0);
        add(0, 8,    1, 1, 4,  1, 0,    1, 1, 1, 0,  0);
        add(0, 12,   0, 1, 8,  1, 0,    1, 0, 1, 4,  0);
        add(0, 12,   0, 0, 0,  1, 0,    1, 0, 1, 8,  0);
        add(0, 12,   0, 0, 0,  1, 0,    1, 0, 0, 0,  0);
        add(1, 0,    0, 0, 0,  1, 0,    0, 0, 0, 0,  0);
        // decode stalled: credits stop after four grants
        add(0, 0,    1, 0, 0,  0, 0,    1, 1, 0, 0,  0);
        add(0, 4,    1, 1, 0,  0, 0,    1, 1, 0, 0,  0);
        add(0, 8,    1, 1, 4,  0, 0,    1, 1, 1, 0,  0);
        add(0, 12,   1, 1, 8,  0, 0,    1, 1, 1, 0,  0);
        add(0, 16,   1, 1, 12, 0, 0,    0, 0, 1, 0,  0);
        add(0, 16,   1, 0, 0,  0, 0,    0, 0, 1, 0,  0);
        // decode resumes: one grant per pop, order kept, no gaps
        add(0, 16,   1, 0, 0,  1, 0,    0, 0, 1, 0,  0);
        add(0, 16,   1, 0, 0,  1, 0,    1, 1, 1, 4,  0);
        add(0, 20,   1, 1, 16, 1, 0,    1, 1, 1, 8,  0);
        add(0, 24,   1, 1, 20, 1, 0,    1, 1, 1, 12, 0);
        add(0, 28,   1, 1, 24, 1, 0,    1, 1, 1, 16, 0);
        add(0, 32,   0, 1, 28, 1, 0,    1, 0, 1, 20, 0);
        // two outstanding + one buffered, then redirect to 0x100
        add(0, 32,   1, 0, 0,  1, 0,    1, 1, 1, 24, 0);
        add(0, 36,   1, 0, 0,  0, 0,    1, 1, 1, 28, 0);
        add(0, 40,   1, 0, 0,  0, 1,    0, 0, 1, 28, 0);
        add(0, 'h100,1, 1, 32, 1, 0,    0, 0, 0, 0,  0);
        add(0, 'h100,1, 0, 0,  1, 0,    0, 0, 0, 0,  0);
        add(0, 'h100,1, 1, 36, 1, 0,    0, 0, 0, 0,  0);
        add(0, 'h100,1, 0, 0,  1, 0,    1, 1, 0, 0,  0);
        // redirect coinciding with the only outstanding response
        add(0, 'h104,0, 1, 'h100,1,1,   0, 0, 0, 0,  0);
        add(0, 'h200,1, 0, 0,  1, 0,    1, 1, 0, 0,  0);
        add(0, 'h204,0, 1, 'h200,1,0,   1, 0, 0, 0,  0);
        add(0, 'h204,0, 0, 0,  1, 0,    1, 0, 1, 'h200, 0);
        add(0, 'h204,0, 0, 0,  1, 0,    1, 0, 0, 0,  0);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].fpc, vq[i].gnt, vq[i].rv, word_of(vq[i].rpc),
                  vq[i].rdy, vq[i].redir);
            chk_out($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_adv, vq[i].e_vld,
                    vq[i].e_pc, vq[i].e_err);
        end

        // unexpected response with one word buffered
        drive(0, 'h300, 1, 0, 0, 0, 0);
        chk_out("ue0", 1, 1, 0, 0, 0);
        drive(0, 'h304, 0, 1, word_of('h300), 0, 0);
        chk_out("ue1", 1, 0, 0, 0, 0);
        drive(0, 'h304, 0, 1, 32'h999, 0, 0);
        chk_out("ue2", 1, 0, 1, 'h300, 0);
        drive(0, 'h304, 0, 0, 0, 0, 0);
        chk_out("ue3", 1, 0, 1, 'h300, 1);
        drive(0, 'h304, 0, 0, 0, 1, 0);
        chk_out("ue4", 1, 0, 1, 'h300, 1);
        drive(0, 'h304, 0, 0, 0, 1, 0);
        chk_out("ue5", 1, 0, 0, 0, 1);

        // reset with three requests in flight
        drive(1, 'h400, 0, 0, 0, 0, 0);
        chk_out("rs0", 0, 0, 0, 0, 1);
        drive(0, 'h400, 1, 0, 0, 0, 0);
        chk_out("rs1", 1, 1, 0, 0, 0);
        drive(0, 'h404, 1, 0, 0, 0, 0);
        chk_out("rs2", 1, 1, 0, 0, 0);
        drive(0, 'h408, 1, 0, 0, 0, 0);
        chk_out("rs3", 1, 1, 0, 0, 0);
        drive(1, 'h40C, 1, 0, 0, 0, 0);
        chk_out("rs4", 0, 0, 0, 0, 0);
        drive(1, 'h40C, 1, 0, 0, 0, 0);
        chk_out("rs5", 0, 0, 0, 0, 0);
        drive(0, 'h40C, 0, 1, word_of('h400), 0, 0);
        chk_out("rs6", 1, 0, 0, 0, 0);
        drive(0, 'h40C, 0, 1, word_of('h404), 0, 0);
        chk_out("rs7", 1, 0, 0, 0, 1);
        drive(0, 'h40C, 0, 0, 0, 0, 0);
        chk_out("rs8", 1, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
